se_scale_broadcast: RTL and testbench

- Return path of the global-average-pooling stage, used in the squeeze-and-excitation block. The pooler reduces an HxW channel to one value; this block expands one per-channel scale value back over all HxW pixel positions of that channel.
- Per channel, it accepts one scale value through a valid/ready handshake. It then multiplies each incoming feature pixel by that scale and streams out exactly HxW scaled pixels.
- It pulses ch_done on the last pixel of the channel, then returns to accept the next scale.

---
 rtl/pooling_pkg.sv | 51 +++++
 rtl/se_scale_mul.sv | 33 +++
 rtl/se_scale_broadcast.sv | 108 ++++++++++
 tb/tb_se_scale_broadcast.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pooling_pkg
// Purpose  : Shared definitions for the squeeze-and-excitation pooling path.
//            Both the global-average pooler and the scale broadcaster use
//            this one size encoding, so the two ends of the path always agree
//            on channel geometry.
// Contents : size encoding, per-size pixel counts, pooler reciprocals,
//            broadcaster FSM state type, size -> pixel count helper.
// Revision : 1.0 - initial release
// ============================================================================
package pooling_pkg;

  // Spatial size code carried on the 2-bit size port.
  typedef enum logic [1:0] {
    SZ_28x28 = 2'b00,
    SZ_14x14 = 2'b01,
    SZ_7x7   = 2'b10,
    SZ_RSVD  = 2'b11
  } size_e;

  // Number of pixels per channel for each spatial size.
  localparam int unsigned c_CNT_28X28 = 784;
  localparam int unsigned c_CNT_14X14 = 196;
  localparam int unsigned c_CNT_7X7   = 49;

  // Pooler reciprocals 1/N in unsigned Q0.16, rounded to nearest.
  localparam int unsigned c_RECIP_FRAC  = 16;
  localparam int unsigned c_RECIP_28X28 = 84;    // 65536/784 = 83.59
  localparam int unsigned c_RECIP_14X14 = 334;   // 65536/196 = 334.37
  localparam int unsigned c_RECIP_7X7   = 1337;  // 65536/49  = 1337.47

  // Broadcaster states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Pixel count for a size code; the reserved code falls back to 7x7.
  function automatic int unsigned size_to_count(input logic [1:0] sz);
    int unsigned n;
    case (sz)
      SZ_28x28: n = c_CNT_28X28;
      SZ_14x14: n = c_CNT_14X14;
      default:  n = c_CNT_7X7;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/se_scale_mul.sv
`default_nettype none
// ============================================================================
// Module   : se_scale_mul
// Purpose  : Combinational fixed-point scale of one pixel:
//            (pix * scale) >> FRAC_BITS, truncated, saturated to DATA_W bits.
// Ports    : i_pix   [DATA_W-1:0]  unsigned pixel
//            i_scale [DATA_W-1:0]  unsigned scale, FRAC_BITS fractional bits
//            o_res   [DATA_W-1:0]  scaled, saturated result
// Revision : 1.0 - initial release
// ============================================================================
module se_scale_mul #(
  parameter int DATA_W    = 9,
  parameter int FRAC_BITS = 8
) (
  input  logic [DATA_W-1:0] i_pix,
  input  logic [DATA_W-1:0] i_scale,
  output logic [DATA_W-1:0] o_res
);

  localparam int c_PROD_W = 2 * DATA_W;

  logic [c_PROD_W-1:0] w_prod;
  logic [c_PROD_W-1:0] w_shift;
  logic                w_ovf;

  assign w_prod  = c_PROD_W'(i_pix) * c_PROD_W'(i_scale);
  assign w_shift = w_prod >> FRAC_BITS;
  // Any bit above the output width means the result does not fit.
  assign w_ovf   = |w_shift[c_PROD_W-1:DATA_W];
  assign o_res   = w_ovf ? {DATA_W{1'b1}} : w_shift[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/se_scale_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : se_scale_broadcast
// Purpose  : Accepts one scale per channel, then multiplies each of the
//            channel's HxW incoming pixels by it and streams the results.
//            ch_done marks the last pixel of the channel.
// Ports    : clk, reset_n          clock / async active-low reset
//            scale_in/_valid/_ready per-channel scale handshake
//            size                  spatial size code, sampled with the scale
//            pix_in/_valid/_ready  pixel handshake
//            data_out              scaled pixel (registered)
//            valid_data_out        one pulse per accepted pixel, 1 cycle later
//            ch_done               pulse with the channel's last output
// Revision : 1.0 - initial release
// ============================================================================
module se_scale_broadcast
  import pooling_pkg::*;
#(
  parameter int DATA_W    = 9,
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] scale_in,
  input  logic              scale_valid,
  output logic              scale_ready,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_data_out,
  output logic              ch_done
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_target;
  logic [DATA_W-1:0] r_scale;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;

  logic [DATA_W-1:0] w_scaled;
  logic              w_pix_acc;
  logic              w_last;

  se_scale_mul #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .i_pix   (pix_in),
    .i_scale (r_scale),
    .o_res   (w_scaled)
  );

  assign scale_ready = (r_state == IDLE);
  assign pix_ready   = (r_state == STREAM);

  assign w_pix_acc = (r_state == STREAM) && pix_valid;
  assign w_last    = w_pix_acc && (r_count == (r_target - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_scale  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid <= w_pix_acc;
      r_done  <= w_last;
      if (w_pix_acc) begin
        r_data <= w_scaled;
      end
      case (r_state)
        IDLE: begin
          if (scale_valid) begin
            r_scale  <= scale_in;
            r_target <= CNT_W'(size_to_count(size));
            r_count  <= '0;
            r_state  <= STREAM;
          end
        end
        STREAM: begin
          if (w_pix_acc) begin
            r_count <= r_count + CNT_W'(1);
            // Leaving STREAM here creates the one-cycle IDLE bubble
            // before the next scale can be taken.
            if (w_last) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out       = r_data;
  assign valid_data_out = r_valid;
  assign ch_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_se_scale_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_se_scale_broadcast
// Purpose  : Self-checking bench for se_scale_broadcast. Channel vectors
//            with hand-computed outputs are applied from a table; the
//            mid-channel reset is a hand-written sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_se_scale_broadcast;

  localparam int DATA_W    = 9;
  localparam int FRAC_BITS = 8;
  localparam int CNT_W     = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] scale_in = '0;
  logic              scale_valid = 1'b0;
  logic              scale_ready;
  logic [1:0]        size = 2'b10;
  logic [DATA_W-1:0] pix_in = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_data_out;
  logic              ch_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  se_scale_broadcast #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .scale_in       (scale_in),
    .scale_valid    (scale_valid),
    .scale_ready    (scale_ready),
    .size           (size),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .data_out       (data_out),
    .valid_data_out (valid_data_out),
    .ch_done        (ch_done)
  );

  // One channel: size code, scale, constant pixel value, expected output,
  // expected length, random pix_valid, hold pix_valid through the bubble,
  // change size mid-stream, abort after this many pixels (0 = never).
  typedef struct {
    logic [1:0] sz;
    int         sc;
    int         pix;
    int         exp;
    int         len;
    bit         rnd;
    bit         hold;
    bit         midchg;
    int         abort;
  } vec_t;

  vec_t tab [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Starts at a falling edge with the block in IDLE; returns at a falling edge.
  task automatic run_channel(input vec_t v);
    int sent;
    int got;
    int dones;
    int cyc;
    bit pv;
    bit prev_acc;
    bit done_loop;
    sent = 0; got = 0; dones = 0; cyc = 0; prev_acc = 1'b0; done_loop = 1'b0;

    size        = v.sz;
    scale_in    = v.sc[DATA_W-1:0];
    scale_valid = 1'b1;
    chk("scale_ready_idle", 32'(scale_ready), 1);
    chk("pix_ready_idle", 32'(pix_ready), 0);
    @(negedge clk);
    scale_valid = 1'b0;
    scale_in    = '0;
    chk("pix_ready_stream", 32'(pix_ready), 1);
    chk("scale_ready_stream", 32'(scale_ready), 0);

    while (!done_loop) begin
      if (sent < v.len && !(v.abort > 0 && sent >= v.abort))
        pv = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      else
        pv = 1'b0;
      if (v.midchg && sent == 10) size = 2'b00;
      pix_valid = pv;
      pix_in    = v.pix[DATA_W-1:0];
      prev_acc  = pv && pix_ready;
      if (prev_acc) sent++;
      @(negedge clk);
      cyc++;
      chk("valid_latency", 32'(valid_data_out), 32'(prev_acc));
      if (valid_data_out) begin
        got++;
        chk("data_out", 32'(data_out), v.exp);
        chk("ch_done_pos", 32'(ch_done), 32'(got == v.len));
        if (ch_done) dones++;
      end else begin
        chk("ch_done_quiet", 32'(ch_done), 0);
      end
      if (got == v.len) done_loop = 1'b1;
      else if (v.abort > 0 && sent >= v.abort) begin
        pix_valid = 1'b0;
        return;
      end else if (cyc > 4 * v.len + 100) begin
        total++;
        bad++;
        $display("FAIL channel_timeout: got %0d outputs expected %0d", got, v.len);
        pix_valid = 1'b0;
        return;
      end
    end

    chk("out_count", 32'(got), 32'(v.len));
    chk("ch_done_count", 32'(dones), 1);
    chk("scale_ready_after", 32'(scale_ready), 1);
    chk("pix_ready_after", 32'(pix_ready), 0);

    // Bubble / IDLE: pixels offered here must be ignored.
    pix_valid = v.hold;
    repeat (3) begin
      @(negedge clk);
      chk("bubble_no_valid", 32'(valid_data_out), 0);
      chk("bubble_no_done", 32'(ch_done), 0);
      chk("bubble_scale_ready", 32'(scale_ready), 1);
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    vec_t rv;
    //           sz     sc   pix  exp  len rnd hold mid abort
    tab[0]  = '{2'b10, 256, 100, 100,  49, 0, 0, 0, 0};
    tab[1]  = '{2'b10, 128, 200, 100,  49, 0, 0, 0, 0};
    tab[2]  = '{2'b10,   3,  85,   0,  49, 0, 0, 0, 0};  // 255>>8 truncates
    tab[3]  = '{2'b10, 511, 511, 511,  49, 0, 0, 0, 0};  // 1020 saturates
    tab[4]  = '{2'b00, 256,  37,  37, 784, 1, 1, 0, 0};
    tab[5]  = '{2'b01,  64, 400, 100, 196, 0, 1, 0, 0};  // 25600>>8
    tab[6]  = '{2'b11, 300,  10,  11,  49, 0, 0, 0, 0};  // reserved = 7x7
    tab[7]  = '{2'b10, 384, 341, 511,  49, 0, 0, 0, 0};  // 130944>>8 = 511 exact fit
    tab[8]  = '{2'b10, 257, 511, 511,  49, 0, 0, 0, 0};  // 512 saturates
    tab[9]  = '{2'b10, 200,  77,  60,  49, 1, 0, 0, 0};  // 15400>>8
    tab[10] = '{2'b10, 256,   5,   5,  49, 0, 0, 1, 0};  // size -> 00 mid-stream

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_valid", 32'(valid_data_out), 0);
    chk("rst_ch_done", 32'(ch_done), 0);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_scale_ready", 32'(scale_ready), 1);

    // IDLE ignores pixels.
    pix_valid = 1'b1;
    pix_in    = 9'd50;
    @(negedge clk);
    chk("idle_ignores_pix", 32'(valid_data_out), 0);
    pix_valid = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_channel(tab[i]);
    end

    // Reset after 300 of 784 pixels.
    rv = '{2'b00, 256, 37, 37, 784, 0, 0, 0, 300};
    run_channel(rv);
    chk("pre_reset_valid", 32'(valid_data_out), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data_out", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(valid_data_out), 0);
    chk("mid_rst_ch_done", 32'(ch_done), 0);
    chk("mid_rst_pix_ready", 32'(pix_ready), 0);
    chk("mid_rst_scale_ready", 32'(scale_ready), 1);
    @(negedge clk);
    reset_n   = 1'b1;
    pix_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(valid_data_out), 0);
      chk("post_rst_no_done", 32'(ch_done), 0);
    end
    pix_valid = 1'b0;
    run_channel(tab[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
